audio_in: RTL

Audio input front end: the receive-side counterpart of the mixer/DAC output path. Forms a first-order sigma-delta ADC with an external comparator and RC network. It synchronises the comparator bit and drives it back as the feedback bit. It decimates the bitstream into 8-bit PCM samples and derives a hysteresis-filtered 1-bit EAR level for the tape/ULA input port.

---
 rtl/audio_pkg.sv | 17 +
 rtl/ds_decim.sv | 52 +++++
 rtl/audio_in.sv | 71 +++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio types and defaults for the sigma-delta input front end and the mixer path.
package audio_pkg;

  localparam int unsigned SAMPLE_W  = 8;
  localparam int unsigned DECIM_DEF = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  localparam sample_t HI_DEF = 8'd160;
  localparam sample_t LO_DEF = 8'd96;

  typedef enum logic {
    EAR_LOW  = 1'b0,
    EAR_HIGH = 1'b1
  } ear_t;

endpackage

// File: rtl/ds_decim.sv
// Sigma-delta decimator: counts feedback ones over a 2^DECIM-clock window into an 8-bit sample.
module ds_decim
  import audio_pkg::*;
#(
  parameter int unsigned DECIM = DECIM_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                fb_i,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                valid_o
);

  logic [DECIM-1:0] win_q, win_d;
  logic [DECIM:0]   acc_q, acc_d;
  logic [DECIM:0]   sum;
  logic             wrap;
  sample_t          sample_q, sample_d;
  logic             valid_q, valid_d;

  always_comb begin
    wrap     = &win_q;
    win_d    = win_q + DECIM'(1);
    sum      = acc_q + (DECIM+1)'(fb_i);
    acc_d    = wrap ? '0 : sum;
    valid_d  = wrap;
    sample_d = sample_q;
    // The wrap cycle's bit is already in sum; a full window of ones saturates.
    if (wrap) begin
      if (sum[DECIM]) sample_d = '1;
      else            sample_d = sum[DECIM-1 -: SAMPLE_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q    <= '0;
      acc_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      win_q    <= win_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign sample_o = sample_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/audio_in.sv
// Audio input front end: comparator synchroniser / feedback, decimation, and hysteresis EAR level.
module audio_in
  import audio_pkg::*;
#(
  parameter int unsigned DECIM = DECIM_DEF,
  parameter sample_t     HI    = HI_DEF,
  parameter sample_t     LO    = LO_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                comp_i,
  output logic                fb_o,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                valid_o,
  output logic                ear_o,
  output logic                edge_o
);

  logic s1_q, s2_q;
  ear_t ear_q, ear_d;
  logic edge_q, edge_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= comp_i;
      s2_q <= s1_q;
    end
  end

  assign fb_o = s2_q;

  ds_decim #(
    .DECIM(DECIM)
  ) u_decim (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .fb_i    (s2_q),
    .sample_o(sample_o),
    .valid_o (valid_o)
  );

  // Thresholds are only looked at on the strobe, so ear moves at most once per window.
  always_comb begin
    ear_d = ear_q;
    if (valid_o) begin
      unique case (ear_q)
        EAR_LOW:  if (sample_o >= HI) ear_d = EAR_HIGH;
        EAR_HIGH: if (sample_o <= LO) ear_d = EAR_LOW;
        default:  ear_d = ear_q;
      endcase
    end
    edge_d = (ear_d != ear_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ear_q  <= EAR_LOW;
      edge_q <= 1'b0;
    end else begin
      ear_q  <= ear_d;
      edge_q <= edge_d;
    end
  end

  assign ear_o  = (ear_q == EAR_HIGH);
  assign edge_o = edge_q;

endmodule
